// File: rtl/set_mode_pkg.sv
`default_nettype none
// ============================================================================
// set_mode_pkg : state encoding, switch indices and helpers for set_mode_fsm
// Rev 1.0
// ============================================================================
package set_mode_pkg;

  localparam logic ST_NORMAL = 1'b0;
  localparam logic ST_SET    = 1'b1;

  typedef enum logic {
    S_NORMAL = ST_NORMAL,
    S_SET    = ST_SET
  } state_t;

  localparam int SW_ADJ  = 0;
  localparam int SW_MODE = 1;
  localparam int SW_NEXT = 2;
  localparam int NSW     = 3;

  // Bit width needed to hold n distinct values, never below 1
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_rise_rpt.sv
`default_nettype none
// ============================================================================
// sw_rise_rpt : switch history register, rising-edge detect and optional
//               hold-to-repeat tick generator (macro SET_AUTOREPEAT_EN)
// Rev 1.0
// ============================================================================
module sw_rise_rpt
  import set_mode_pkg::*;
#(
  parameter int RPT_DLY = 500,
  parameter int RPT_PER = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  input  logic rpt_en,
  input  logic rpt_clr,
  output logic rise,
  output logic tick
);

  logic sw_q;

  // History resets high so a switch held through reset is not seen as a press
  always_ff @(posedge clk) begin
    if (!rst_n) sw_q <= 1'b1;
    else        sw_q <= sw;
  end

  assign rise = sw & ~sw_q;

`ifdef SET_AUTOREPEAT_EN
  localparam int CW = clog2_min1(((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER) + 1);

  logic [CW-1:0] cnt;
  logic          active;
  logic          rep;

  // cnt holds cycles since the press (or since the last tick once repeating)
  assign tick = active & sw & rpt_en & ~rpt_clr &
                (cnt == (rep ? CW'(RPT_PER) : CW'(RPT_DLY)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      rep    <= 1'b0;
      cnt    <= '0;
    end else if (rpt_clr || !sw) begin
      active <= 1'b0;
      rep    <= 1'b0;
      cnt    <= '0;
    end else if (rise && rpt_en) begin
      active <= 1'b1;
      rep    <= 1'b0;
      cnt    <= CW'(1);
    end else if (tick) begin
      rep <= 1'b1;
      cnt <= CW'(1);
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{rpt_en, rpt_clr, RPT_DLY[0], RPT_PER[0]};
  assign tick       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/set_mode_fsm.sv
`default_nettype none
// ============================================================================
// set_mode_fsm : NORMAL/SET mode controller turning three debounced switches
//                into field select and adjust pulses; SET_AUTOREPEAT_EN adds
//                hold-to-repeat on the adjust switch
// Rev 1.0
// ============================================================================
module set_mode_fsm
  import set_mode_pkg::*;
#(
  parameter int NFIELD  = 3,
  parameter int TMO     = 1000,
  parameter int RPT_DLY = 500,
  parameter int RPT_PER = 100
) (
  input  logic              ck,
  input  logic              sysreset_n,
  input  logic              SW1,
  input  logic              SW2,
  input  logic              SW3,
  output logic              setting,
  output logic [NFIELD-1:0] field_on,
  output logic [NFIELD-1:0] field_adj
);

  localparam int IW = clog2_min1(NFIELD);
  localparam int TW = clog2_min1(TMO + 1);
  localparam logic [NFIELD-1:0] FIELD0 = NFIELD'(1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tmo_cnt;
  logic [NSW-1:0]  sw_lvl;
  logic [NSW-1:0]  rise;
  logic [NSW-1:0]  tick_v;
  logic            in_set;
  logic            tmo_hit;
  logic            leave;
  logic            rpt_clr;
  logic            adj_tick;
  logic            adj_req;
  logic            unused_ticks;

  assign sw_lvl[SW_ADJ]  = SW1;
  assign sw_lvl[SW_MODE] = SW2;
  assign sw_lvl[SW_NEXT] = SW3;

  assign in_set = (state == S_SET);

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    sw_rise_rpt #(
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_sw (
      .clk     (ck),
      .rst_n   (sysreset_n),
      .sw      (sw_lvl[i]),
      .rpt_en  ((i == SW_ADJ) ? in_set  : 1'b0),
      .rpt_clr ((i == SW_ADJ) ? rpt_clr : 1'b1),
      .rise    (rise[i]),
      .tick    (tick_v[i])
    );
  end

  assign adj_tick     = tick_v[SW_ADJ];
  assign unused_ticks = ^{tick_v[SW_MODE], tick_v[SW_NEXT]};

  if (TMO > 0) begin : g_tmo
    assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
  end else begin : g_no_tmo
    assign tmo_hit = 1'b0;
  end

  assign leave   = in_set & (rise[SW_MODE] | tmo_hit);
  assign rpt_clr = ~in_set | leave | rise[SW_NEXT];
  assign adj_req = rise[SW_ADJ] | adj_tick;

  // Lower-priority events in SET are dropped when a higher one fires
  always_ff @(posedge ck) begin
    if (!sysreset_n) begin
      state     <= S_NORMAL;
      idx       <= '0;
      tmo_cnt   <= '0;
      field_adj <= '0;
    end else begin
      field_adj <= '0;
      case (state)
        S_NORMAL: begin
          if (rise[SW_MODE]) begin
            state   <= S_SET;
            idx     <= '0;
            tmo_cnt <= '0;
          end
        end
        S_SET: begin
          if (leave) begin
            state <= S_NORMAL;
          end else if (rise[SW_NEXT]) begin
            idx     <= (idx == '0) ? IW'(NFIELD - 1) : idx - 1'b1;
            tmo_cnt <= '0;
          end else if (adj_req) begin
            field_adj <= FIELD0 << idx;
            tmo_cnt   <= '0;
          end else if (tmo_cnt != {TW{1'b1}}) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_NORMAL;
      endcase
    end
  end

  assign setting = in_set;

  for (genvar f = 0; f < NFIELD; f++) begin : g_field_on
    assign field_on[f] = in_set && (idx == IW'(f));
  end

endmodule
`default_nettype wire

// File: tb/tb_set_mode_fsm.sv
`default_nettype none
// ============================================================================
// tb_set_mode_fsm : directed bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
module tb_set_mode_fsm;

  localparam int NF      = 3;
  localparam int TMO     = 32;
  localparam int RPT_DLY = 8;
  localparam int RPT_PER = 4;

  logic          ck;
  logic          sysreset_n;
  logic          SW1, SW2, SW3;
  logic          setting;
  logic [NF-1:0] field_on;
  logic [NF-1:0] field_adj;

  int errors = 0;
  int checks = 0;

  set_mode_fsm #(
    .NFIELD  (NF),
    .TMO     (TMO),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) dut (
    .ck         (ck),
    .sysreset_n (sysreset_n),
    .SW1        (SW1),
    .SW2        (SW2),
    .SW3        (SW3),
    .setting    (setting),
    .field_on   (field_on),
    .field_adj  (field_adj)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode flag, selected field, idle age and SW1 hold age
  bit            m_valid = 1'b0;
  bit            m_set;
  int            m_idx, m_idle, m_hold;
  bit            p1, p2, p3;
  logic          exp_set;
  logic [NF-1:0] exp_on, exp_adj;

  always @(posedge ck) begin
    bit r1, r2, r3, tk;
    int adj;
    adj = -1;
    tk  = 1'b0;
    if (!sysreset_n) begin
      m_set = 0; m_idx = 0; m_idle = 0; m_hold = -1;
      p1 = 1; p2 = 1; p3 = 1;
      m_valid = 1'b1;
    end else begin
      r1 = SW1 && !p1;
      r2 = SW2 && !p2;
      r3 = SW3 && !p3;
      if (!SW1) m_hold = -1;
`ifdef SET_AUTOREPEAT_EN
      if (m_set && m_hold >= RPT_DLY && ((m_hold - RPT_DLY) % RPT_PER) == 0) tk = 1'b1;
`endif
      if (!m_set) begin
        if (r2) begin m_set = 1; m_idx = 0; m_idle = 0; end
        m_hold = -1;
      end else if (r2 || m_idle == TMO - 1) begin
        m_set = 0; m_hold = -1;
      end else if (r3) begin
        m_idx = (m_idx + NF - 1) % NF; m_idle = 0; m_hold = -1;
      end else if (r1 || tk) begin
        adj = m_idx; m_idle = 0;
        m_hold = r1 ? 1 : m_hold + 1;
      end else begin
        m_idle++;
        if (m_hold >= 0) m_hold++;
      end
      p1 = SW1; p2 = SW2; p3 = SW3;
    end
    exp_set = m_set;
    exp_on  = m_set ? NF'(1 << m_idx) : '0;
    exp_adj = (adj >= 0) ? NF'(1 << adj) : '0;
  end

  always @(negedge ck) begin
    if (m_valid) begin
      check("model_setting",   32'(setting),   32'(exp_set));
      check("model_field_on",  32'(field_on),  32'(exp_on));
      check("model_field_adj", 32'(field_adj), 32'(exp_adj));
    end
  end

  task automatic set_sw(input int k, input logic v);
    case (k)
      1: SW1 = v;
      2: SW2 = v;
      default: SW3 = v;
    endcase
  endtask

  // One-cycle press; returns at the negedge just after the sampling edge
  task automatic tap(input int k);
    set_sw(k, 1'b1);
    @(negedge ck);
    set_sw(k, 1'b0);
  endtask

  logic [2:0]  on_seq [3];
  logic [31:0] seen;

  initial begin
    on_seq[0] = 3'b100; on_seq[1] = 3'b010; on_seq[2] = 3'b001;
    sysreset_n = 1'b0; SW1 = 1'b0; SW2 = 1'b1; SW3 = 1'b0;
    repeat (3) @(negedge ck);
    check("reset_setting",   32'(setting),   32'd0);
    check("reset_field_on",  32'(field_on),  32'd0);
    check("reset_field_adj", 32'(field_adj), 32'd0);

    // SW2 held through reset must not enter SET
    sysreset_n = 1'b1;
    repeat (5) @(negedge ck);
    check("held_sw2_no_edge", 32'(setting), 32'd0);
    tap(1); tap(3);
    check("normal_ignores_sw1_sw3", 32'({setting, field_on, field_adj}), 32'd0);
    SW2 = 1'b0;
    @(negedge ck);
    tap(2);
    check("enter_setting",  32'(setting),  32'd1);
    check("enter_field_on", 32'(field_on), 32'b001);

    // Field stepping and per-field adjust pulses
    for (int i = 0; i < 3; i++) begin
      tap(3);
      check("step_field_on", 32'(field_on), 32'(on_seq[i]));
      @(negedge ck);
      tap(1);
      check("adj_pulse", 32'(field_adj), 32'(on_seq[i]));
      @(negedge ck);
      check("adj_one_cycle", 32'(field_adj), 32'd0);
    end

    // Simultaneous rises: higher priority wins, adjust dropped
    SW1 = 1'b1; SW3 = 1'b1;
    @(negedge ck);
    SW1 = 1'b0; SW3 = 1'b0;
    check("sw1_sw3_idx",  32'(field_on),  32'b100);
    check("sw1_sw3_adj",  32'(field_adj), 32'd0);
    @(negedge ck);
    SW1 = 1'b1; SW2 = 1'b1;
    @(negedge ck);
    SW1 = 1'b0; SW2 = 1'b0;
    check("sw1_sw2_exit", 32'({setting, field_on, field_adj}), 32'd0);
    @(negedge ck);

    // Inactivity timeout, then timeout restart by an adjust press
    tap(2);
    check("reentry_idx0", 32'(field_on), 32'b001);
    repeat (31) @(negedge ck);
    check("tmo_still_set_31", 32'(setting), 32'd1);
    @(negedge ck);
    check("tmo_dropped_32", 32'(setting), 32'd0);
    tap(2);
    repeat (19) @(negedge ck);
    tap(1);
    check("tmo_restart_adj", 32'(field_adj), 32'b001);
    repeat (31) @(negedge ck);
    check("tmo_restart_still_set", 32'(setting), 32'd1);
    @(negedge ck);
    check("tmo_restart_dropped", 32'(setting), 32'd0);

    // SW1 held for 20 cycles
    tap(2);
    SW1  = 1'b1;
    seen = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge ck);
      if (field_adj != '0) seen[k] = 1'b1;
      if (k == 20) SW1 = 1'b0;
    end
`ifdef SET_AUTOREPEAT_EN
    check("repeat_pattern", seen, 32'h0002_2202);
`else
    check("single_pulse_pattern", seen, 32'h0000_0002);
`endif

    // Reset on the edge that samples an SW1 press
    check("pre_reset_setting", 32'(setting), 32'd1);
    SW1 = 1'b1; sysreset_n = 1'b0;
    @(negedge ck);
    check("mid_reset_outputs", 32'({setting, field_on, field_adj}), 32'd0);
    sysreset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      check("post_reset_no_adj", 32'(field_adj), 32'd0);
    end
    SW1 = 1'b0;
    @(negedge ck);
    tap(2);
    check("post_reset_enter", 32'(field_on), 32'b001);
    tap(1);
    check("post_reset_adj", 32'(field_adj), 32'b001);
    repeat (2) @(negedge ck);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
